oh_csa_accum: RTL and testbench
===============================

// Module: oh_csa_accum
// PURPOSE
//  Multi-operand carry-save accumulator built from a tree of 4:2 compressors.
//  Each accepted beat adds N unsigned DW-bit operands into a redundant (sum,carry)
//  state; the state is held in AW-bit registers. A beat flagged last triggers a
//  carry-propagate resolve and a held, handshaked result. Used for dot-product,
//  checksum and MAC reduction datapaths.
// PARAMETERS
//  DW  8     operand width
//  N   4     operands per beat; even, 2..16
//  AW  DW+8  accumulator/result width; all arithmetic modulo 2^AW
//  CW  16    beat counter width
// PORTS
//  clk        in   1     clock
//  nreset     in   1     async active-low reset
//  clear      in   1     sync flush: drop accumulation, return to ACC
//  in_valid   in   1     operand beat valid
//  in_ready   out  1     accumulator can accept a beat
//  in_last    in   1     final beat of the current accumulation
//  in_data    in   N*DW  operands; operand k = in_data[k*DW+:DW]
//  out_valid  out  1     result valid
//  out_ready  in   1     downstream accepts result
//  out_data   out  AW    resolved sum of all operands of the accumulation
//  out_beats  out  CW    beats in the accumulation, saturating at 2^CW-1
// BEHAVIOUR
//  - Reset (async, nreset=0): state ACC, S=C=0, beat count=0, out_valid=0,
//    out_data=0, out_beats=0, in_ready=1.
//  - Operands zero-extended to AW. Compressor tree reduces {S,C,op0..opN-1}
//    to a new (S,C) in one cycle; C is shifted left 1 and truncated to AW.
//  - Beat accepted when in_valid & in_ready. in_ready = (state==ACC) & ~clear.
//  - FSM:
//    ACC: accepted beat updates S,C and count+1 (sat). Accepted in_last -> RES.
//    RES: out_data <= S+C (mod 2^AW), out_beats <= count; S,C,count <= 0;
//         out_valid <= 1 -> OUT. in_ready=0.
//    OUT: out_valid=1, out_data/out_beats held stable; out_ready -> ACC with
//         out_valid <= 0. in_ready=0.
//  - Latency: last beat accepted at cycle t -> out_valid high at t+2.
//  - Throughput: one beat per cycle in ACC; min 3 cycles between results.
//  - Boundary cases:
//    single beat with in_last: result = sum of its N operands.
//    overflow past 2^AW: silent wrap, no flag.
//    count at 2^CW-1: holds; out_beats reports saturated value.
//    in_valid in RES/OUT: not accepted; upstream must hold the beat.
//    clear in any state: next cycle ACC, S=C=count=0, out_valid=0; clear wins
//      over a simultaneous beat or out_ready. Outputs hold last values except
//      out_valid.
//    out_ready while out_valid=0: ignored.
//    nreset mid-accumulation: all state to reset values immediately.
// CONFIGURATION
//  OH_CSA_ACCUM_PIPE_EN defined: CPA split in two halves with registered carry;
//   RES lasts 2 cycles (RES0 low half, RES1 high half + carry), latency t+3.
//  Not defined: single-cycle RES, latency t+2. All other behaviour identical.
// TESTING (DW=8,N=4,AW=16,CW=16; latencies per no-macro build, +1 with macro)
//  1 one beat {1,2,3,4}, last -> out_valid at t+2, out_data=10, out_beats=1.
//  2 3 beats all 0xFF, last on 3rd -> out_data=3060 (0x0BF4), out_beats=3.
//  3 300 beats all 0xFF -> out_data=306000 mod 65536=43856 (0xAB50), wraps.
//  4 result held with out_ready=0 for 5 cycles; in_valid=1 -> in_ready=0,
//    out_data stable; out_ready=1 -> ACC next cycle, next beat accepted.
//  5 2 beats then clear with in_valid=1 -> beat dropped, new 1-beat {5,0,0,0}
//    last -> out_data=5, out_beats=1.
//  6 nreset low mid-accumulation and in OUT -> out_valid=0, in_ready=1 next cycle;
//    random streams vs. reference sum model, both macro settings.

Source files
------------

// File: rtl/oh_csa_accum.sv
// oh_csa_accum
//   Multi-operand carry-save accumulator. Each accepted beat folds N unsigned
//   DW-bit operands into a redundant (sum, carry) state through a chain of
//   4:2 compressors. A beat flagged last resolves the state with a
//   carry-propagate add. The result is then held until the consumer takes it.
//   All arithmetic is modulo 2^AW.
//
// Ports
//   clk        in   clock
//   nreset     in   async active-low reset
//   clear      in   sync flush back to ACC; wins over beats and out_ready
//   in_valid   in   operand beat valid
//   in_ready   out  accumulator accepts a beat this cycle
//   in_last    in   final beat of the accumulation
//   in_data    in   N operands, operand k = in_data[k*DW +: DW]
//   out_valid  out  result valid
//   out_ready  in   consumer takes the result
//   out_data   out  resolved sum (held between results)
//   out_beats  out  beat count of the accumulation, saturating
//
// Configuration
//   OH_CSA_ACCUM_PIPE_EN : split the resolve add into a low half and a high
//   half, with a registered carry between them. This adds one cycle of
//   latency.
//
// States
//   ST_ACC  | accepting beats into (S,C)
//   ST_RES  | resolve (low half when pipelined)
//   ST_RES1 | high half + carry (pipelined build only)
//   ST_OUT  | result held until out_ready
module oh_csa_accum #(
  parameter int DW = 8,
  parameter int N  = 4,
  parameter int AW = DW + 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic [N*DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_data,
  output logic [CW-1:0]   out_beats
);

  typedef enum logic [1:0] {ST_ACC, ST_RES, ST_RES1, ST_OUT} state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_s, r_c;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] w_s_nxt, w_c_nxt;
  logic [AW-1:0] w_x3, w_x4, w_t, w_co;
  logic [CW-1:0] w_cnt_inc;
  logic          w_accept;
  logic          w_final;
  logic [AW-1:0] w_res;

  assign in_ready  = (r_state == ST_ACC) & ~clear;
  assign out_valid = (r_state == ST_OUT);
  assign w_accept  = in_valid & in_ready;
  assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  // Each stage is a word-wide 4:2 compressor taking {S, C, op2k, op2k+1}.
  // The intermediate carry (w_co) plays the role of the horizontal cin/cout
  // and is pre-shifted, so both outputs are already at weight-aligned
  // positions.
  always_comb begin
    w_s_nxt = r_s;
    w_c_nxt = r_c;
    w_x3    = '0;
    w_x4    = '0;
    w_t     = '0;
    w_co    = '0;
    for (int k = 0; k < N / 2; k++) begin
      w_x3    = AW'(in_data[2*k*DW +: DW]);
      w_x4    = AW'(in_data[(2*k+1)*DW +: DW]);
      w_t     = w_s_nxt ^ w_c_nxt ^ w_x3;
      w_co    = ((w_s_nxt & w_c_nxt) | (w_s_nxt & w_x3) | (w_c_nxt & w_x3)) << 1;
      w_c_nxt = ((w_t & w_x4) | (w_t & w_co) | (w_x4 & w_co)) << 1;
      w_s_nxt = w_t ^ w_x4 ^ w_co;
    end
  end

`ifdef OH_CSA_ACCUM_PIPE_EN
  localparam int LW = AW / 2;
  localparam int HW = AW - LW;
  logic [LW-1:0] r_lo;
  logic          r_cy;
  logic [LW:0]   w_lo_sum;

  assign w_lo_sum = {1'b0, r_s[LW-1:0]} + {1'b0, r_c[LW-1:0]};
  assign w_res    = {r_s[AW-1:LW] + r_c[AW-1:LW] + HW'(r_cy), r_lo};
  assign w_final  = (r_state == ST_RES1);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_lo <= '0;
      r_cy <= 1'b0;
    end else if (r_state == ST_RES) begin
      r_lo <= w_lo_sum[LW-1:0];
      r_cy <= w_lo_sum[LW];
    end
  end
`else
  assign w_res   = r_s + r_c;
  assign w_final = (r_state == ST_RES);
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= ST_ACC;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = ST_ACC;
    end else begin
      case (r_state)
        ST_ACC:  if (w_accept && in_last) w_next = ST_RES;
`ifdef OH_CSA_ACCUM_PIPE_EN
        ST_RES:  w_next = ST_RES1;
`else
        ST_RES:  w_next = ST_OUT;
`endif
        ST_RES1: w_next = ST_OUT;
        ST_OUT:  if (out_ready) w_next = ST_ACC;
        default: w_next = ST_ACC;
      endcase
    end
  end

  // clear drops the accumulation but leaves out_data/out_beats at their last
  // values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_s       <= '0;
      r_c       <= '0;
      r_cnt     <= '0;
      out_data  <= '0;
      out_beats <= '0;
    end else if (clear) begin
      r_s   <= '0;
      r_c   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_s   <= w_s_nxt;
      r_c   <= w_c_nxt;
      r_cnt <= w_cnt_inc;
    end else if (w_final) begin
      out_data  <= w_res;
      out_beats <= r_cnt;
      r_s       <= '0;
      r_c       <= '0;
      r_cnt     <= '0;
    end
  end

endmodule

// File: tb/tb_oh_csa_accum.sv
module tb_oh_csa_accum;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int CW = 16;
`ifdef OH_CSA_ACCUM_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [31:0]   in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [AW-1:0] out_data;
  logic [CW-1:0] out_beats;
  // second instance with a 4-bit counter to reach saturation quickly
  logic          in_ready_s, out_valid_s;
  logic [AW-1:0] out_data_s;
  logic [3:0]    out_beats_s;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oh_csa_accum #(.DW(DW), .N(N), .AW(AW), .CW(CW)) dut (
    .clk(clk), .nreset(nreset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats));

  oh_csa_accum #(.DW(DW), .N(N), .AW(AW), .CW(4)) dut_s (
    .clk(clk), .nreset(nreset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_beats(out_beats_s));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a running sum plus beat count. After a last beat the
  // model is busy for LAT-1 edges, and then holds the result until it is
  // taken.
  longint m_sum, m_res_sum;
  int     m_cnt, m_res_cnt, m_wait;
  bit     m_valid;
  longint m_out_data;
  int     m_out_beats;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_sum = 0; m_cnt = 0; m_wait = 0; m_valid = 0;
      m_res_sum = 0; m_res_cnt = 0; m_out_data = 0; m_out_beats = 0;
    end else if (clear) begin
      m_sum = 0; m_cnt = 0; m_wait = 0; m_valid = 0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1;
        m_out_data = m_res_sum % 65536;
        m_out_beats = m_res_cnt;
      end
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (in_valid) begin
      for (int k = 0; k < N; k++) m_sum += (in_data >> (8 * k)) & 32'hFF;
      if (m_cnt < 65535) m_cnt++;
      if (in_last) begin
        m_res_sum = m_sum; m_res_cnt = m_cnt;
        m_sum = 0; m_cnt = 0; m_wait = LAT - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (nreset) begin
      chk("in_ready", in_ready, (m_wait == 0 && !m_valid && !clear));
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_out_data);
      chk("out_beats", out_beats, m_out_beats);
      chk("in_ready_s", in_ready_s, (m_wait == 0 && !m_valid && !clear));
      chk("out_valid_s", out_valid_s, m_valid);
      chk("out_data_s", out_data_s, m_out_data);
      chk("out_beats_s", out_beats_s, (m_out_beats > 15) ? 15 : m_out_beats);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [31:0] d, input bit last);
    int n;
    in_valid = 1; in_data = d; in_last = last;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("beat_accept_timeout", 0, 1);
        break;
      end
    end
    step();
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_result(input string nm, input longint d, input longint b, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (lat > 20) begin
        chk({nm, "_timeout"}, 0, 1);
        break;
      end
    end
    chk({nm, "_data"}, out_data, d);
    chk({nm, "_beats"}, out_beats, b);
  endtask

  task automatic take();
    step(); out_ready = 1; step(); out_ready = 0;
  endtask

  initial begin
    int lat;
    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_beats", out_beats, 0);
    step(); nreset = 1; step();

    // single beat
    beat({8'd4, 8'd3, 8'd2, 8'd1}, 1);
    wait_result("t1", 10, 1, lat);
    chk("t1_latency", lat, LAT);
    take();

    // three max beats
    for (int i = 0; i < 3; i++) beat(32'hFFFF_FFFF, i == 2);
    wait_result("t2", 3060, 3, lat);
    take();

    // wrap past 2^AW
    for (int i = 0; i < 300; i++) beat(32'hFFFF_FFFF, i == 299);
    wait_result("t3", 43856, 300, lat);

    // backpressure: result held while a beat waits
    step();
    in_valid = 1; in_data = 32'h0000_0009; in_last = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_ready", in_ready, 0);
      chk("t4_hold_data", out_data, 43856);
      step();
    end
    out_ready = 1; step(); out_ready = 0;
    @(negedge clk);
    chk("t4_ready_after_take", in_ready, 1);
    step(); in_valid = 0; in_last = 0;
    wait_result("t4", 9, 1, lat);
    take();

    // clear drops the accumulation and a simultaneous beat
    beat(32'h0101_0101, 0);
    beat(32'h0202_0202, 0);
    clear = 1; in_valid = 1; in_data = 32'h0303_0303;
    step();
    clear = 0; in_valid = 0;
    chk("t5_data_held_after_clear", out_data, 9);
    beat({8'd0, 8'd0, 8'd0, 8'd5}, 1);
    wait_result("t5", 5, 1, lat);
    take();

    // count saturation in the 4-bit instance
    for (int i = 0; i < 21; i++) beat(32'h0000_0001, i == 20);
    wait_result("sat", 21, 21, lat);
    chk("sat_beats_s", out_beats_s, 15);
    take();

    // async reset mid-accumulation
    beat(32'h1111_1111, 0);
    beat(32'h2222_2222, 0);
    #2 nreset = 0; #1;
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_valid", out_valid, 0);
    step(); nreset = 1; step();
    beat(32'h0000_0007, 1);
    wait_result("t6a", 7, 1, lat);
    // async reset while holding a result
    #2 nreset = 0; #1;
    chk("t6_out_rst_valid", out_valid, 0);
    chk("t6_out_rst_data", out_data, 0);
    step(); nreset = 1; step();

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      in_last   = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      clear     = ($urandom_range(0, 99) < 2);
      step();
    end
    in_valid = 0; in_last = 0; clear = 0; out_ready = 1;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
